// File: rtl/mcu_mem_pkg.sv
// Shared types and helpers for the MCU memory controller.
package mcu_mem_pkg;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP, PREFETCH} state_t;

   typedef enum logic [1:0] {ACC_CODE_INT, ACC_CODE_EXT, ACC_RAM_RD, ACC_RAM_WR} acc_t;

   localparam int unsigned WAIT_W = 4;

   // Code address served by the internal ROM when EA is high.
   function automatic logic in_int_rom(input logic ea, input logic [15:0] a,
                                       input int unsigned depth);
      return ea && (32'(a) < depth);
   endfunction

   function automatic logic [15:0] next_addr(input logic [15:0] a);
      return a + 16'd1;
   endfunction

endpackage

// File: rtl/mcu_int_rom.sv
// Synchronous-read internal code ROM; contents zero-initialised.
module mcu_int_rom
  import mcu_mem_pkg::*;
#(
  parameter int unsigned DEPTH     = 4096,
  parameter int unsigned ADDR_W    = 12,
  parameter string       INIT_FILE = ""
) (
  input  logic              clk_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] addr_i,
  output logic [7:0]        rdata_o
);

  logic [7:0] rom_mem [DEPTH];
  logic [7:0] rdata_q;

  initial begin
    for (int unsigned i = 0; i < DEPTH; i++) rom_mem[i] = '0;
  end

  always_ff @(posedge clk_i) begin
    if (en_i) rdata_q <= rom_mem[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mcu_mem_ctrl.sv
// CPU-side memory controller: internal ROM, external code bus and external RAM bus.
// Optional one-byte sequential code prefetch buffer enabled by MCU_MEM_PREFETCH_EN.
module mcu_mem_ctrl
   import mcu_mem_pkg::*;
#(
   parameter int unsigned INT_ROM_DEPTH = 4096,
   parameter int unsigned CODE_WAIT     = 2,
   parameter int unsigned DATA_WAIT     = 1,
   parameter string       ROM_INIT_FILE = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addr_bus,
   input  logic        read_en,
   input  logic        write_en,
   input  logic        memory_select,
   input  logic        PSEN,
   input  logic        EA,
   input  logic [7:0]  cpu_wdata,
   output logic [7:0]  cpu_rdata,
   output logic        ready,
   output logic        bus_err,
   output logic [15:0] ext_addr,
   output logic        ext_code_rd,
   output logic        ext_ram_rd,
   output logic        ext_ram_wr,
   output logic [7:0]  ext_wdata,
   input  logic [7:0]  ext_rdata
);

   localparam int unsigned ROM_AW = (INT_ROM_DEPTH > 1) ? $clog2(INT_ROM_DEPTH) : 1;

   state_t            state_q, state_d;
   acc_t              acc_q, acc_d;
   logic [15:0]       addr_q, addr_d;
   logic [7:0]        wdata_q, wdata_d;
   logic [7:0]        rdata_q, rdata_d;
   logic [WAIT_W-1:0] wcnt_q, wcnt_d;
   logic              berr_q, berr_d;
   logic              drop_q, drop_d;
   logic [7:0]        rom_rdata;

`ifdef MCU_MEM_PREFETCH_EN
   logic              ea_q, ea_d;
   logic              pf_pend_q, pf_pend_d;
   logic              hit_q, hit_d;
   logic              buf_vld_q, buf_vld_d;
   logic              buf_ea_q, buf_ea_d;
   logic [15:0]       buf_addr_q, buf_addr_d;
   logic [7:0]        buf_q, buf_d;
`endif

   logic req, req_drop, bad_req;
   assign req      = read_en | write_en;
   assign req_drop = write_en & ~memory_select;
   assign bad_req  = (read_en & write_en) | req_drop
                   | (read_en & ~write_en & ~memory_select & ~PSEN);

   mcu_int_rom #(
      .DEPTH     (INT_ROM_DEPTH),
      .ADDR_W    (ROM_AW),
      .INIT_FILE (ROM_INIT_FILE)
   ) u_rom (
      .clk_i   (clk),
      .en_i    (state_q == ACCESS && acc_q == ACC_CODE_INT),
      .addr_i  (addr_q[ROM_AW-1:0]),
      .rdata_o (rom_rdata)
   );

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      wcnt_d  = wcnt_q;
      berr_d  = berr_q;
      drop_d  = drop_q;
`ifdef MCU_MEM_PREFETCH_EN
      ea_d       = ea_q;
      pf_pend_d  = pf_pend_q;
      hit_d      = hit_q;
      buf_vld_d  = buf_vld_q;
      buf_ea_d   = buf_ea_q;
      buf_addr_d = buf_addr_q;
      buf_d      = buf_q;
      // Buffered byte and pending fetch were decoded under the old EA.
      if (buf_vld_q && EA != buf_ea_q) buf_vld_d = 1'b0;
      if (pf_pend_q && EA != ea_q)     pf_pend_d = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (req) begin
               state_d = ACCESS;
               addr_d  = addr_bus;
               berr_d  = berr_q | bad_req;
               drop_d  = req_drop;
               wcnt_d  = '0;
`ifdef MCU_MEM_PREFETCH_EN
               ea_d      = EA;
               pf_pend_d = 1'b0;
               hit_d     = 1'b0;
`endif
               if (write_en) begin
                  acc_d = ACC_RAM_WR;
                  if (!req_drop) begin
                     wdata_d = cpu_wdata;
                     wcnt_d  = WAIT_W'(DATA_WAIT);
`ifdef MCU_MEM_PREFETCH_EN
                     buf_vld_d = 1'b0;
`endif
                  end
               end else if (memory_select) begin
                  acc_d  = ACC_RAM_RD;
                  wcnt_d = WAIT_W'(DATA_WAIT);
               end else if (in_int_rom(EA, addr_bus, INT_ROM_DEPTH)) begin
                  acc_d = ACC_CODE_INT;
               end else begin
                  acc_d  = ACC_CODE_EXT;
                  wcnt_d = WAIT_W'(CODE_WAIT);
`ifdef MCU_MEM_PREFETCH_EN
                  if (buf_vld_q && EA == buf_ea_q && addr_bus == buf_addr_q) begin
                     state_d = RESP;
                     hit_d   = 1'b1;
                  end else begin
                     buf_vld_d = 1'b0;
                  end
`endif
               end
            end
`ifdef MCU_MEM_PREFETCH_EN
            else if (pf_pend_q && EA == ea_q) begin
               state_d   = PREFETCH;
               addr_d    = next_addr(addr_q);
               wcnt_d    = WAIT_W'(CODE_WAIT);
               pf_pend_d = 1'b0;
               buf_vld_d = 1'b0;
            end
`endif
         end
         ACCESS: begin
            if (wcnt_q == '0) begin
               state_d = RESP;
               if (acc_q == ACC_CODE_EXT || acc_q == ACC_RAM_RD) rdata_d = ext_rdata;
            end else begin
               wcnt_d = wcnt_q - 1'b1;
            end
         end
         RESP: begin
            state_d = IDLE;
`ifdef MCU_MEM_PREFETCH_EN
            hit_d = 1'b0;
            if (acc_q == ACC_CODE_EXT && !in_int_rom(ea_q, next_addr(addr_q), INT_ROM_DEPTH))
               pf_pend_d = 1'b1;
`endif
         end
`ifdef MCU_MEM_PREFETCH_EN
         PREFETCH: begin
            // A CPU request always wins; it is sampled from IDLE next cycle.
            if (req) begin
               state_d = IDLE;
            end else if (wcnt_q == '0) begin
               state_d    = IDLE;
               buf_d      = ext_rdata;
               buf_vld_d  = 1'b1;
               buf_addr_d = addr_q;
               buf_ea_d   = ea_q;
            end else begin
               wcnt_d = wcnt_q - 1'b1;
            end
         end
`endif
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         acc_q   <= ACC_CODE_INT;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         wcnt_q  <= '0;
         berr_q  <= 1'b0;
         drop_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         wcnt_q  <= wcnt_d;
         berr_q  <= berr_d;
         drop_q  <= drop_d;
      end
   end

`ifdef MCU_MEM_PREFETCH_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         ea_q       <= 1'b0;
         pf_pend_q  <= 1'b0;
         hit_q      <= 1'b0;
         buf_vld_q  <= 1'b0;
         buf_ea_q   <= 1'b0;
         buf_addr_q <= '0;
         buf_q      <= '0;
      end else begin
         ea_q       <= ea_d;
         pf_pend_q  <= pf_pend_d;
         hit_q      <= hit_d;
         buf_vld_q  <= buf_vld_d;
         buf_ea_q   <= buf_ea_d;
         buf_addr_q <= buf_addr_d;
         buf_q      <= buf_d;
      end
   end
`endif

   always_comb begin
      cpu_rdata = '0;
      if (state_q == RESP) begin
`ifdef MCU_MEM_PREFETCH_EN
         if (hit_q) cpu_rdata = buf_q;
         else
`endif
         if (acc_q == ACC_CODE_INT)    cpu_rdata = rom_rdata;
         else if (acc_q != ACC_RAM_WR) cpu_rdata = rdata_q;
      end
   end

   assign ready      = (state_q == RESP);
   assign bus_err    = berr_q;
   assign ext_addr   = addr_q;
   assign ext_wdata  = wdata_q;
   assign ext_ram_rd = (state_q == ACCESS) && (acc_q == ACC_RAM_RD);
   assign ext_ram_wr = (state_q == ACCESS) && (acc_q == ACC_RAM_WR) && !drop_q;
   assign ext_code_rd = ((state_q == ACCESS) && (acc_q == ACC_CODE_EXT))
                      || (state_q == PREFETCH);

endmodule

// File: tb/tb_mcu_mem_ctrl.sv
// Directed self-checking bench for mcu_mem_ctrl (default parameters).
module tb_mcu_mem_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] addr_bus;
   logic        read_en, write_en, memory_select, PSEN, EA;
   logic [7:0]  cpu_wdata, cpu_rdata, ext_wdata, ext_rdata;
   logic        ready, bus_err, ext_code_rd, ext_ram_rd, ext_ram_wr;
   logic [15:0] ext_addr;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mcu_mem_ctrl #(
      .INT_ROM_DEPTH (4096),
      .CODE_WAIT     (2),
      .DATA_WAIT     (1),
      .ROM_INIT_FILE ("")
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .addr_bus      (addr_bus),
      .read_en       (read_en),
      .write_en      (write_en),
      .memory_select (memory_select),
      .PSEN          (PSEN),
      .EA            (EA),
      .cpu_wdata     (cpu_wdata),
      .cpu_rdata     (cpu_rdata),
      .ready         (ready),
      .bus_err       (bus_err),
      .ext_addr      (ext_addr),
      .ext_code_rd   (ext_code_rd),
      .ext_ram_rd    (ext_ram_rd),
      .ext_ram_wr    (ext_ram_wr),
      .ext_wdata     (ext_wdata),
      .ext_rdata     (ext_rdata)
   );

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      read_en = 1'b0; write_en = 1'b0; memory_select = 1'b0;
      PSEN = 1'b0; cpu_wdata = '0; addr_bus = '0;
   endtask

   // Holds one request until ready; ext_rdata carries the real byte only in the last read-strobe cycle.
   task automatic run_req(input string tag, input logic rd, input logic wr, input logic ms,
                          input logic ps, input logic [15:0] a, input logic [7:0] wd,
                          input logic [7:0] ext_d, input int exp_lat, input int exp_c,
                          input int exp_r, input int exp_w, input logic [7:0] exp_rd);
      int   nc, nr, nw;
      logic got;
      nc = 0; nr = 0; nw = 0; got = 1'b0;
      read_en = rd; write_en = wr; memory_select = ms; PSEN = ps;
      addr_bus = a; cpu_wdata = wd; ext_rdata = 8'h3C;
      for (int k = 1; k <= 30 && !got; k++) begin
         step();
         if (ext_code_rd) nc++;
         if (ext_ram_rd)  nr++;
         if (ext_ram_wr)  nw++;
         ext_rdata = ((ext_code_rd || ext_ram_rd) && (nc + nr == exp_c + exp_r)) ? ext_d : 8'h3C;
         if (ready) begin
            got = 1'b1;
            check_eq({tag, "_lat"}, k, exp_lat);
            check_eq({tag, "_rdata"}, cpu_rdata, exp_rd);
            if (exp_c + exp_r + exp_w > 0) check_eq({tag, "_addr"}, ext_addr, a);
            if (exp_w > 0) check_eq({tag, "_wdata"}, ext_wdata, wd);
         end
      end
      if (!got) check_eq({tag, "_timeout"}, 0, 1);
      check_eq({tag, "_strobes"}, {8'(nc), 8'(nr), 8'(nw)}, {8'(exp_c), 8'(exp_r), 8'(exp_w)});
      idle_inputs();
      step();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic seen;
      reset = 1'b1; EA = 1'b1; ext_rdata = '0;
      idle_inputs();
      repeat (5) @(posedge clk);
      #1 reset = 1'b0;
      step();
      check_eq("rst_ctrl", {ready, bus_err, ext_code_rd, ext_ram_rd, ext_ram_wr}, 0);
      check_eq("rst_data", {ext_addr, cpu_rdata, ext_wdata}, 0);

      dut.u_rom.rom_mem[16'h0010] = 8'h60;
      dut.u_rom.rom_mem[16'h0020] = 8'h5A;
      dut.u_rom.rom_mem[16'h0FFF] = 8'h7E;

      run_req("rom_0010", 1, 0, 0, 1, 16'h0010, 8'h00, 8'hEE, 2, 0, 0, 0, 8'h60);
      run_req("rom_0fff", 1, 0, 0, 1, 16'h0FFF, 8'h00, 8'hEE, 2, 0, 0, 0, 8'h7E);
      run_req("ext_1000", 1, 0, 0, 1, 16'h1000, 8'h00, 8'hA5, 4, 3, 0, 0, 8'hA5);
      EA = 1'b0;
      run_req("ea0_0010", 1, 0, 0, 1, 16'h0010, 8'h00, 8'h11, 4, 3, 0, 0, 8'h11);
      EA = 1'b1;
      run_req("ram_wr",   0, 1, 1, 0, 16'h0030, 8'h50, 8'hEE, 3, 0, 0, 2, 8'h00);
      run_req("ram_rd",   1, 0, 1, 0, 16'h0030, 8'h00, 8'h50, 3, 0, 2, 0, 8'h50);
      check_eq("berr_clean", bus_err, 0);

      run_req("rw_both",  1, 1, 1, 0, 16'h0040, 8'h77, 8'hEE, 3, 0, 0, 2, 8'h00);
      check_eq("berr_set", bus_err, 1);
      run_req("ram_rd2",  1, 0, 1, 0, 16'h0040, 8'h00, 8'h77, 3, 0, 2, 0, 8'h77);
      check_eq("berr_sticky", bus_err, 1);
      run_req("wr_drop",  0, 1, 0, 0, 16'h0050, 8'h12, 8'hEE, 2, 0, 0, 0, 8'h00);
      run_req("no_psen",  1, 0, 0, 0, 16'h0020, 8'h00, 8'hEE, 2, 0, 0, 0, 8'h5A);
      check_eq("berr_sticky2", bus_err, 1);

      // Reset while a RAM write strobe is active.
      read_en = 1'b0; write_en = 1'b1; memory_select = 1'b1;
      addr_bus = 16'h0060; cpu_wdata = 8'h99;
      step();
      check_eq("midrst_pre", ext_ram_wr, 1);
      reset = 1'b1;
      step();
      check_eq("midrst_strb", {ext_code_rd, ext_ram_rd, ext_ram_wr, ready}, 0);
      check_eq("midrst_berr", bus_err, 0);
      idle_inputs();
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         seen = seen | ready | ext_ram_wr;
      end
      check_eq("midrst_quiet", seen, 0);
      run_req("post_rst", 1, 0, 1, 0, 16'h0030, 8'h00, 8'h50, 3, 0, 2, 0, 8'h50);

`ifdef MCU_MEM_PREFETCH_EN
      begin
         int npf;
         EA = 1'b0;
         run_req("pf_ffff", 1, 0, 0, 1, 16'hFFFF, 8'h00, 8'h99, 4, 3, 0, 0, 8'h99);
         npf = 0;
         ext_rdata = 8'h3C;
         for (int i = 0; i < 8; i++) begin
            step();
            if (ext_code_rd && ext_addr == 16'h0000) npf++;
            ext_rdata = (ext_code_rd && npf == 3) ? 8'h42 : 8'h3C;
         end
         check_eq("pf_strobes", npf, 3);
         run_req("pf_hit", 1, 0, 0, 1, 16'h0000, 8'h00, 8'hEE, 1, 0, 0, 0, 8'h42);
      end
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
